// File: rtl/alu_ex_stage_if.sv
// Upstream instruction handshake and downstream EX-result handshake of alu_ex_stage.
// master drives instructions and consumes results; slave is the execute stage.
interface alu_ex_stage_if #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_imm;
    logic [RD_W-1:0]  in_rd;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [RD_W-1:0]  out_rd;
    logic             out_wb_en;
    logic             out_branch_taken;
    logic             out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, in_imm, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wb_en,
               out_branch_taken, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_imm, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wb_en,
               out_branch_taken, out_illegal
    );
endinterface

// File: rtl/alu_ex_stage.sv
// Execute-stage issuer: decodes instructions onto an external combinational ALU and
// registers the result, branch decision and counters into a valid/ready output slot.
module alu_ex_stage #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    alu_ex_stage_if.slave    bus,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_gt,
    output logic [15:0]      issue_count,
    output logic [15:0]      taken_count
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_BNE  = 4'd7;
    localparam logic [3:0] OP_BLT  = 4'd8;
    localparam logic [3:0] OP_BGT  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic [RD_W-1:0]  rd_q;
    logic             wb_en_q;
    logic             taken_q;
    logic             illegal_q;
    logic [15:0]      issue_q;
    logic [15:0]      taken_cnt_q;

    logic             accept;
    logic             eq;
    logic             lt_q;
    logic             gt_q;
    logic [WIDTH-1:0] result_d;
    logic             wb_en_d;
    logic             taken_d;
    logic             illegal_d;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        alu_data1 = bus.in_a;
        alu_data2 = bus.in_b;
        alu_op    = ALU_ADD;
        case (bus.in_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: alu_op = bus.in_op;
            OP_ADDI: alu_data2 = bus.in_imm;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT, OP_SLT: alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase
    end

    // The ALU leaves lt/gt stale on equal operands, so zero gates both.
    assign eq   = alu_zero;
    assign lt_q = alu_lt && !alu_zero;
    assign gt_q = alu_gt && !alu_zero;

    always_comb begin
        result_d  = alu_result;
        wb_en_d   = 1'b0;
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        case (bus.in_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: wb_en_d = 1'b1;
            OP_BEQ: taken_d = eq;
            OP_BNE: taken_d = !eq;
            OP_BLT: taken_d = lt_q;
            OP_BGT: taken_d = gt_q;
            OP_SLT: begin
                result_d = {{(WIDTH-1){1'b0}}, lt_q};
                wb_en_d  = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            wb_en_q     <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            issue_q     <= 16'd0;
            taken_cnt_q <= 16'd0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            result_q  <= result_d;
            rd_q      <= bus.in_rd;
            wb_en_q   <= wb_en_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            issue_q   <= issue_q + 16'd1;
            if (taken_d) begin
                taken_cnt_q <= taken_cnt_q + 16'd1;
            end
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid        = valid_q;
    assign bus.out_result       = result_q;
    assign bus.out_rd           = rd_q;
    assign bus.out_wb_en        = wb_en_q;
    assign bus.out_branch_taken = taken_q;
    assign bus.out_illegal      = illegal_q;
    assign issue_count          = issue_q;
    assign taken_count          = taken_cnt_q;
endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: behavioural ALU with stale lt/gt on equal operands, plus an
// instruction-level reference model tracking the output slot and counters.
module tb_alu_ex_stage;
    localparam int WIDTH = 16;
    localparam int RD_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_ex_stage_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();

    logic [WIDTH-1:0] alu_data1, alu_data2, alu_result;
    logic [3:0]       alu_op;
    logic             alu_zero;
    logic             alu_lt = 1'b0;
    logic             alu_gt = 1'b0;
    logic [15:0]      issue_count, taken_count;

    alu_ex_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_gt(alu_gt),
        .issue_count(issue_count), .taken_count(taken_count)
    );

    // ALU: lt/gt only refresh when operands differ
    always @(alu_data1 or alu_data2 or alu_op) begin
        case (alu_op)
            4'd0:    alu_result = alu_data1 + alu_data2;
            4'd1:    alu_result = alu_data1 - alu_data2;
            4'd2:    alu_result = alu_data1 & alu_data2;
            4'd3:    alu_result = alu_data1 | alu_data2;
            4'd4:    alu_result = alu_data1 ^ alu_data2;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
        if (alu_data1 != alu_data2) begin
            alu_lt = (alu_data1 < alu_data2);
            alu_gt = (alu_data1 > alu_data2);
        end
    end

    int total = 0;
    int bad   = 0;

    logic        m_valid = 1'b0;
    logic [15:0] m_result = '0;
    logic [2:0]  m_rd = '0;
    logic        m_wb = 1'b0, m_taken = 1'b0, m_ill = 1'b0;
    int          m_issue = 0, m_tcnt = 0;

    function automatic void ref_exec(input logic [3:0] op, input logic [15:0] a, b, imm,
                                     output logic [15:0] r, output logic wb, tk, il);
        r = a - b; wb = 1'b0; tk = 1'b0; il = 1'b0;
        case (op)
            4'd0: begin r = a + b; wb = 1'b1; end
            4'd1: begin r = a - b; wb = 1'b1; end
            4'd2: begin r = a & b; wb = 1'b1; end
            4'd3: begin r = a | b; wb = 1'b1; end
            4'd4: begin r = a ^ b; wb = 1'b1; end
            4'd5: begin r = a + imm; wb = 1'b1; end
            4'd6: tk = (a == b);
            4'd7: tk = (a != b);
            4'd8: tk = (a < b);
            4'd9: tk = (a > b);
            4'd10: begin r = (a < b) ? 16'd1 : 16'd0; wb = 1'b1; end
            default: begin r = a + b; il = 1'b1; end
        endcase
    endfunction

    function automatic logic [3:0] exp_alu_op(input logic [3:0] op);
        if (op <= 4'd4) return op;
        if (op >= 4'd6 && op <= 4'd10) return 4'd1;
        return 4'd0;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a, b, imm,
                         input logic [2:0] rd, input logic ordy);
        bus.in_valid = v; bus.in_op = op; bus.in_a = a; bus.in_b = b;
        bus.in_imm = imm; bus.in_rd = rd; bus.out_ready = ordy;
    endtask

    // Advance one clock edge and update the reference model from the driven inputs
    task automatic tick();
        logic [15:0] r;
        logic wb, tk, il, acc;
        ref_exec(bus.in_op, bus.in_a, bus.in_b, bus.in_imm, r, wb, tk, il);
        acc = bus.in_valid && (!m_valid || bus.out_ready);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_result = '0; m_rd = '0; m_wb = 0; m_taken = 0; m_ill = 0;
            m_issue = 0; m_tcnt = 0;
        end else if (acc) begin
            m_valid = 1; m_result = r; m_rd = bus.in_rd; m_wb = wb; m_taken = tk; m_ill = il;
            m_issue = (m_issue + 1) % 65536;
            if (tk) m_tcnt = (m_tcnt + 1) % 65536;
        end else if (bus.out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'd0, 16'd4, 16'd4, 16'd0, 3'd1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 3'd0, 1'b1);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_result !== 16'd0) begin bad++; $display("FAIL rst_result got=%h want=0", bus.out_result); end
        total++; if ({bus.out_rd, bus.out_wb_en, bus.out_branch_taken, bus.out_illegal} !== 6'd0) begin bad++; $display("FAIL rst_flags got=%b want=0", {bus.out_rd, bus.out_wb_en, bus.out_branch_taken, bus.out_illegal}); end
        total++; if (issue_count !== 16'd0 || taken_count !== 16'd0) begin bad++; $display("FAIL rst_counts got=%h/%h want=0/0", issue_count, taken_count); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_add();
        drive(1'b1, 4'd0, 16'd1, 16'd2, 16'd0, 3'd3, 1'b1);
        #1;
        total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL add_alu_op got=%h want=0", alu_op); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'd3) begin bad++; $display("FAIL add_out got=%b/%h want=1/0003", bus.out_valid, bus.out_result); end
        total++; if (bus.out_wb_en !== 1'b1 || bus.out_rd !== 3'd3) begin bad++; $display("FAIL add_wb_rd got=%b/%0d want=1/3", bus.out_wb_en, bus.out_rd); end
        total++; if (issue_count !== 16'd1) begin bad++; $display("FAIL add_issue got=%h want=1", issue_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_r [5];
        exp_r = '{16'h0FFF, 16'hF1E1, 16'h0000, 16'h0FFF, 16'h0FFF};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i), 16'h00F0, 16'h0F0F, 16'd0, 3'(i), 1'b1);
            #1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, bus.in_ready); end
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp_r[i]) begin bad++; $display("FAIL b2b_result[%0d] got=%b/%h want=1/%h", i, bus.out_valid, bus.out_result, exp_r[i]); end
        end
    endtask

    task automatic test_branch();
        drive(1'b1, 4'd8, 16'd5, 16'd9, 16'd0, 3'd1, 1'b1);
        tick();
        total++; if (bus.out_branch_taken !== 1'b1 || bus.out_wb_en !== 1'b0) begin bad++; $display("FAIL blt_5_9 got=%b/%b want=1/0", bus.out_branch_taken, bus.out_wb_en); end
        drive(1'b1, 4'd6, 16'd7, 16'd7, 16'd0, 3'd2, 1'b1);
        tick();
        total++; if (bus.out_branch_taken !== 1'b1) begin bad++; $display("FAIL beq_7_7 got=%b want=1", bus.out_branch_taken); end
        drive(1'b1, 4'd8, 16'd7, 16'd7, 16'd0, 3'd3, 1'b1);
        tick();
        total++; if (bus.out_branch_taken !== 1'b0) begin bad++; $display("FAIL blt_7_7_stale got=%b want=0", bus.out_branch_taken); end
        drive(1'b1, 4'd10, 16'd7, 16'd7, 16'd0, 3'd4, 1'b1);
        tick();
        total++; if (bus.out_result !== 16'd0 || bus.out_wb_en !== 1'b1) begin bad++; $display("FAIL slt_7_7 got=%h/%b want=0000/1", bus.out_result, bus.out_wb_en); end
        total++; if (taken_count !== 16'd2) begin bad++; $display("FAIL branch_taken_count got=%h want=2", taken_count); end
    endtask

    task automatic test_backpressure();
        logic [15:0] iss;
        drive(1'b1, 4'd3, 16'h1234, 16'h00FF, 16'd0, 3'd5, 1'b1);
        tick();
        iss = 16'(m_issue);
        drive(1'b1, 4'd4, 16'hAAAA, 16'h0F0F, 16'd0, 3'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, bus.in_ready); end
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h12FF || bus.out_rd !== 3'd5) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d want=1/12ff/5", i, bus.out_valid, bus.out_result, bus.out_rd); end
            total++; if (issue_count !== iss) begin bad++; $display("FAIL bp_issue[%0d] got=%h want=%h", i, issue_count, iss); end
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'hA5A5 || bus.out_rd !== 3'd6) begin bad++; $display("FAIL bp_next got=%b/%h/%0d want=1/a5a5/6", bus.out_valid, bus.out_result, bus.out_rd); end
        total++; if (issue_count !== iss + 16'd1) begin bad++; $display("FAIL bp_issue_after got=%h want=%h", issue_count, iss + 16'd1); end
        drive(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 3'd0, 1'b1);
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_illegal_addi();
        logic [15:0] iss;
        iss = 16'(m_issue);
        drive(1'b1, 4'd12, 16'h0101, 16'h0202, 16'd0, 3'd2, 1'b1);
        tick();
        total++; if (bus.out_illegal !== 1'b1 || bus.out_wb_en !== 1'b0 || bus.out_branch_taken !== 1'b0) begin bad++; $display("FAIL illegal_flags got=%b%b%b want=100", bus.out_illegal, bus.out_wb_en, bus.out_branch_taken); end
        total++; if (issue_count !== iss + 16'd1) begin bad++; $display("FAIL illegal_issue got=%h want=%h", issue_count, iss + 16'd1); end
        drive(1'b1, 4'd5, 16'hFFFF, 16'h1234, 16'd1, 3'd7, 1'b1);
        tick();
        total++; if (bus.out_result !== 16'h0000 || bus.out_wb_en !== 1'b1 || bus.out_illegal !== 1'b0) begin bad++; $display("FAIL addi_wrap got=%h/%b/%b want=0000/1/0", bus.out_result, bus.out_wb_en, bus.out_illegal); end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        v, ordy;
        for (int i = 0; i < 400; i++) begin
            op   = 4'($urandom_range(0, 15));
            a    = 16'($urandom);
            b    = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            drive(v, op, a, b, 16'($urandom), 3'($urandom), ordy);
            #1;
            total++; if (bus.in_ready !== (!m_valid || ordy)) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, bus.in_ready, !m_valid || ordy); end
            total++; if (alu_op !== exp_alu_op(op)) begin bad++; $display("FAIL rnd_alu_op[%0d] got=%h want=%h", i, alu_op, exp_alu_op(op)); end
            tick();
            total++; if (bus.out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, bus.out_valid, m_valid); end
            if (m_valid) begin
                total++; if ({bus.out_result, bus.out_rd, bus.out_wb_en, bus.out_branch_taken, bus.out_illegal} !== {m_result, m_rd, m_wb, m_taken, m_ill}) begin bad++; $display("FAIL rnd_data[%0d] got=%h/%0d/%b%b%b want=%h/%0d/%b%b%b", i, bus.out_result, bus.out_rd, bus.out_wb_en, bus.out_branch_taken, bus.out_illegal, m_result, m_rd, m_wb, m_taken, m_ill); end
            end
            total++; if (issue_count !== 16'(m_issue) || taken_count !== 16'(m_tcnt)) begin bad++; $display("FAIL rnd_counts[%0d] got=%h/%h want=%h/%h", i, issue_count, taken_count, 16'(m_issue), 16'(m_tcnt)); end
        end
    endtask

    task automatic test_wrap_and_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 4'd6, 16'd3, 16'd3, 16'd0, 3'd1, 1'b1);
        for (int i = 0; i < 65535; i++) tick();
        total++; if (issue_count !== 16'hFFFF || taken_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h/%h want=ffff/ffff", issue_count, taken_count); end
        tick();
        total++; if (issue_count !== 16'h0000 || taken_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h/%h want=0000/0000", issue_count, taken_count); end
        drive(1'b1, 4'd0, 16'd9, 16'd1, 16'd0, 3'd4, 1'b0);
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL pre_rst_stall got=%b/%b want=1/0", bus.out_valid, bus.in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%b/%b want=0/1", bus.out_valid, bus.in_ready); end
        total++; if (issue_count !== 16'd0 || taken_count !== 16'd0) begin bad++; $display("FAIL midrst_counts got=%h/%h want=0/0", issue_count, taken_count); end
    endtask

    initial begin
        drive(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 3'd0, 1'b1);
        test_reset();
        test_add();
        test_back_to_back();
        test_branch();
        test_backpressure();
        test_illegal_addi();
        test_random();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute-stage issuer that sits in front of the 16-bit combinational `ALU` and drives its `data1`/`data2`/`aluoperation` inputs. It decodes an instruction-level opcode into the 4-bit ALU operation code. It consumes the ALU's `result`/`zero`/`lt`/`gt` and registers them into a valid/ready EX output register, adding branch resolution, set-less-than, and issue/branch counters.

## Interface
- WIDTH, 16, datapath width (ALU operand/result width)
- RD_W, 3, destination-register index width
- clk  in  1  clock
- rst  in  1  reset (one clock; synchronous, active-high)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_op  in  4  instruction opcode (encoding below)
- in_a, in_b, in_imm  in  WIDTH each  register operands, immediate
- in_rd  in  RD_W  destination register
- alu_data1, alu_data2  out  WIDTH  to ALU operands (combinational)
- alu_op  out  4  to ALU aluoperation (combinational)
- alu_result  in  WIDTH; alu_zero, alu_lt, alu_gt  in  1  from ALU
- out_valid  out  1; out_ready  in  1  downstream handshake
- out_result  out  WIDTH; out_rd  out  RD_W; out_wb_en  out  1; out_branch_taken  out  1; out_illegal  out  1
- issue_count, taken_count  out  16  wrapping counters

## Operation
- Accept when in_valid && in_ready; in_ready = !out_valid || out_ready.
- in_op encoding -> alu_op / operands: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR -> alu_op 0..4, data1=in_a, data2=in_b; 5 ADDI -> alu_op 0, data2=in_imm; 6 BEQ, 7 BNE, 8 BLT, 9 BGT, 10 SLT -> alu_op 1 (SUB), data2=in_b; 11..15 illegal -> alu_op 0, operands in_a/in_b.
- alu_data1/alu_data2/alu_op driven from in_* every cycle regardless of in_valid.
- ALU lt/gt are not driven when data1==data2 (they hold a stale value); stage must use eq = alu_zero and qualify lt_q = alu_lt && !alu_zero, gt_q = alu_gt && !alu_zero. All compares are unsigned.
- Captured on accept: out_result = alu_result for ops 0..5; {WIDTH-1 zeros, lt_q} for SLT; alu_result (the difference) for branches; alu_result for illegal.
- out_wb_en = 1 for ops 0..5 and 10; 0 for branches and illegal.
- out_branch_taken: BEQ eq, BNE !eq, BLT lt_q, BGT gt_q; 0 otherwise.
- out_illegal = 1 only for ops 11..15; out_rd = in_rd.
- issue_count +1 per accept (all ops incl. illegal); taken_count +1 per accept with branch taken; both wrap 0xFFFF -> 0.

## Timing
- Reset: out_valid 0, out_result 0, out_rd 0, out_wb_en 0, out_branch_taken 0, out_illegal 0, issue_count 0, taken_count 0; in_ready 1 in the cycle after reset. In-flight entry discarded; in_valid ignored during the reset cycle.
- Latency: accept in cycle N -> out_valid=1 with data in cycle N+1.
- Backpressure: while out_valid && !out_ready, all out_* held stable and in_ready=0.
- Simultaneous drain+accept (out_valid && out_ready && in_valid): out_valid stays 1, new data replaces old next edge; no bubble, full throughput.
- Drain without accept: out_valid -> 0 next edge; out_* data may hold its last value.
- Counters update on the accept edge, visible in the next cycle.

## Test plan
- Reset then ADD in_a=1, in_b=2, out_ready=1 -> alu_op=0 same cycle; next cycle out_valid=1, out_result=3, out_wb_en=1, issue_count=1.
- Back-to-back ADD/SUB/AND/OR/XOR with in_a=0x00F0, in_b=0x0F0F, streaming -> results 0x0FFF, 0xF1E1, 0x0000, 0x0FFF, 0x0FFF on consecutive cycles, in_ready constantly 1.
- BLT in_a=5, in_b=9 -> taken 1; then BEQ 7,7 with ALU model holding lt=1 -> taken 1; then BLT 7,7 -> taken 0 (stale lt ignored); SLT 7,7 -> out_result 0; taken_count=2.
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_* stable, issue_count unchanged; release -> pending entry drains, next accepted.
- in_op=12 -> out_illegal=1, out_wb_en=0, out_branch_taken=0, issue_count increments; ADDI in_a=0xFFFF, in_imm=1 -> out_result 0x0000.
- Preload issue_count to 0xFFFF via 65535 accepts, one more -> 0; assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, counters 0, in_ready=1.
